data_sram_bridge: RTL and testbench

Converts the data memory stage's single-cycle SRAM-style request into a split address/data handshake on the CPU's data bus, and returns load data. Sits directly downstream of the `memory` alignment stage. It consumes the byte-lane-shifted write strobe and the replicated store data that stage produces. It feeds the raw 32-bit read word back to it as `ram_in`. While a bus transaction is outstanding it stalls the pipeline, and it buffers the result until the pipeline is ready to take it.

---
 rtl/cpu_defs_pkg.sv | 9 +
 rtl/sram_req_buffer.sv | 26 ++
 rtl/data_sram_bridge.sv | 96 +++++++++
 tb/tb_data_sram_bridge.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared types and constants for the data memory path
package cpu_defs_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} sram_state_t;
endpackage

// File: rtl/sram_req_buffer.sv
// sram_req_buffer: holds one captured memory request stable for the bus
module sram_req_buffer
  import cpu_defs_pkg::*;
#(
  parameter int ADDR_W = cpu_defs_pkg::ADDR_W,
  parameter int DATA_W = cpu_defs_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              we_q,
  output logic [1:0]        size_q,
  output logic [3:0]        wen_q,
  output logic [ADDR_W-1:0] addr_q,
  output logic [DATA_W-1:0] wdata_q
);
  // capture the request on load, otherwise keep it untouched
  always_ff @(posedge clk)
    if (reset) {we_q, size_q, wen_q, addr_q, wdata_q} <= '0;
    else if (load) {we_q, size_q, wen_q, addr_q, wdata_q} <= {we, size, wen, addr, wdata};
endmodule

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: turns a single-cycle SRAM request into a split addr/data bus handshake
module data_sram_bridge
  import cpu_defs_pkg::*;
#(
  parameter int ADDR_W = cpu_defs_pkg::ADDR_W,
  parameter int DATA_W = cpu_defs_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [3:0]        mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              pipe_ready,
  input  logic              flush,
  output logic              mem_stall,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);
  sram_state_t       state_q, state_d;
  logic              cancel_q, cancel_d;
  logic [DATA_W-1:0] rdata_q;
  logic              load;
  logic              we_q;
  logic [3:0]        wen_q;

  sram_req_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .we     (mem_we),
    .size   (mem_size),
    .wen    (mem_wen),
    .addr   (mem_addr),
    .wdata  (mem_wdata),
    .we_q   (we_q),
    .size_q (bus_size),
    .wen_q  (wen_q),
    .addr_q (bus_addr),
    .wdata_q(bus_wdata)
  );

  // state, cancel flag and the read word captured on the response
  always_ff @(posedge clk)
    if (reset) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      if (state_q == DATA && bus_data_ok) rdata_q <= bus_rdata;
    end

  // a flush while the bus is busy only marks the result for discard
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        load    = mem_req & ~flush;
        state_d = load ? ADDR : IDLE;
      end
      ADDR: begin
        cancel_d = cancel_q | flush;
        state_d  = bus_addr_ok ? DATA : ADDR;
      end
      DATA: begin
        cancel_d = bus_data_ok ? 1'b0 : cancel_q | flush;
        state_d  = !bus_data_ok ? DATA : (cancel_q | flush) ? IDLE : HOLD;
      end
      HOLD: state_d = (pipe_ready | flush) ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end

  assign bus_req   = state_q == ADDR;
  assign bus_wr    = we_q;
  assign bus_wstrb = we_q ? wen_q : 4'b0000;
  assign mem_done  = state_q == HOLD;
  assign mem_rdata = rdata_q;
  assign mem_stall = (state_q == IDLE && mem_req && !flush) || state_q == ADDR ||
                     (state_q == DATA && !cancel_q);
endmodule

// File: tb/tb_data_sram_bridge.sv
// tb_data_sram_bridge: scenario tests against a transaction-level bus model
module tb_data_sram_bridge;
  logic        clk = 1'b0;
  logic        reset, mem_req, mem_we, pipe_ready, flush;
  logic [1:0]  mem_size, bus_size;
  logic [3:0]  mem_wen, bus_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, bus_addr, bus_wdata, bus_rdata;
  logic        mem_stall, mem_done, bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  int          errors = 0;
  int          checks = 0;

  data_sram_bridge dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pipe_ready(pipe_ready),
    .flush(flush), .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    {mem_req, mem_we, mem_size, mem_wen, mem_addr, mem_wdata} = '0;
    {pipe_ready, flush, bus_addr_ok, bus_data_ok, bus_rdata} = '0;
  endtask

  // One transaction seen from the pipeline: stall until the result is held,
  // request fields equal to what was issued, data equal to what the slave returned.
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd,
                         input int alat, input int dlat, input int hlat, input logic exit_flush);
    int hs = 0;
    mem_req = 1; mem_we = we; mem_size = sz; mem_wen = wen; mem_addr = addr; mem_wdata = wdata;
    flush = 0; pipe_ready = 0; bus_addr_ok = 0; bus_data_ok = 0;
    #1;
    checks++;
    if ({mem_stall, bus_req, mem_done} !== 3'b100) begin
      errors++; $display("FAIL issue got %b exp 100", {mem_stall, bus_req, mem_done});
    end
    tick;
    for (int a = 0; a <= alat; a++) begin
      mem_addr = $urandom; mem_wdata = $urandom; mem_wen = 4'($urandom);
      bus_addr_ok = (a == alat);
      #1;
      if (bus_req && bus_addr_ok) hs++;
      checks++;
      if ({bus_req, mem_stall, mem_done, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !==
          {3'b110, we, sz, we ? wen : 4'b0000, addr, wdata}) begin
        errors++;
        $display("FAIL addr_phase got req=%b stall=%b done=%b wr=%b size=%0d wstrb=%b addr=%h wdata=%h exp wr=%b size=%0d wstrb=%b addr=%h wdata=%h",
                 bus_req, mem_stall, mem_done, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
                 we, sz, we ? wen : 4'b0000, addr, wdata);
      end
      tick;
    end
    for (int d = 0; d <= dlat; d++) begin
      bus_addr_ok = 1'($urandom);
      bus_data_ok = (d == dlat);
      bus_rdata = (d == dlat) ? rd : $urandom;
      #1;
      if (bus_req && bus_addr_ok) hs++;
      checks++;
      if ({bus_req, mem_stall, mem_done} !== 3'b010) begin
        errors++; $display("FAIL data_phase got %b exp 010", {bus_req, mem_stall, mem_done});
      end
      tick;
    end
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = $urandom;
    for (int h = 0; h <= hlat; h++) begin
      pipe_ready = (h == hlat) && !exit_flush;
      flush = (h == hlat) && exit_flush;
      #1;
      checks++;
      if ({bus_req, mem_stall, mem_done, mem_rdata} !== {3'b001, rd}) begin
        errors++;
        $display("FAIL hold got req=%b stall=%b done=%b rdata=%h exp 001 %h",
                 bus_req, mem_stall, mem_done, mem_rdata, rd);
      end
      tick;
    end
    pipe_ready = 0; flush = 0; mem_req = 0;
    #1;
    checks++;
    if ({bus_req, mem_stall, mem_done, hs} !== {3'b000, 32'd1}) begin
      errors++;
      $display("FAIL txn_end got req=%b stall=%b done=%b handshakes=%0d exp 000 1",
               bus_req, mem_stall, mem_done, hs);
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1;
    tick; tick;
    reset = 0;
    #1;
    checks++;
    if ({bus_req, mem_stall, mem_done, mem_rdata, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !== '0) begin
      errors++;
      $display("FAIL reset got req=%b stall=%b done=%b rdata=%h wr=%b size=%0d wstrb=%b addr=%h wdata=%h exp all zero",
               bus_req, mem_stall, mem_done, mem_rdata, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata);
    end
  endtask

  task automatic test_word_load;
    run_txn(0, 2'd2, 4'b1111, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0);
  endtask

  task automatic test_byte_store_slow;
    run_txn(1, 2'd0, 4'b1000, 32'h1003, 32'h5A5A5A5A, 32'h1234_5678, 4, 0, 0, 0);
  endtask

  task automatic test_hold;
    run_txn(0, 2'd1, 4'b1100, 32'h2002, 32'h0, 32'hCAFE_F00D, 0, 1, 3, 0);
  endtask

  task automatic test_flush;
    // flush in IDLE: nothing captured
    mem_req = 1; mem_addr = 32'h3000; flush = 1;
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got %b exp 0", mem_stall); end
    tick;
    mem_req = 0; flush = 0;
    #1;
    checks++;
    if ({bus_req, mem_stall, mem_done} !== 3'b000) begin
      errors++; $display("FAIL flush_idle_req got %b exp 000", {bus_req, mem_stall, mem_done});
    end
    // flush in DATA, response arrives later and is swallowed
    mem_req = 1; mem_addr = 32'h3004;
    tick;
    bus_addr_ok = 1;
    tick;
    bus_addr_ok = 0; flush = 1;
    #1;
    checks++;
    if ({bus_req, mem_stall, mem_done} !== 3'b010) begin
      errors++; $display("FAIL flush_data_same got %b exp 010", {bus_req, mem_stall, mem_done});
    end
    tick;
    flush = 0; mem_req = 0;
    #1;
    checks++;
    if ({bus_req, mem_stall, mem_done} !== 3'b000) begin
      errors++; $display("FAIL flush_data_next got %b exp 000", {bus_req, mem_stall, mem_done});
    end
    tick;
    bus_data_ok = 1; bus_rdata = 32'hBAD0_BAD0;
    tick;
    bus_data_ok = 0;
    #1;
    tick;
    checks++;
    if ({bus_req, mem_stall, mem_done} !== 3'b000) begin
      errors++; $display("FAIL flush_data_drop got %b exp 000", {bus_req, mem_stall, mem_done});
    end
    run_txn(0, 2'd2, 4'b1111, 32'h3008, 32'h0, 32'h0BAD_CAFE, 0, 0, 0, 0);
    // flush together with the response
    mem_req = 1; mem_addr = 32'h300C;
    tick;
    bus_addr_ok = 1;
    tick;
    bus_addr_ok = 0; flush = 1; bus_data_ok = 1; bus_rdata = 32'h1111_2222;
    tick;
    flush = 0; bus_data_ok = 0; mem_req = 0;
    #1;
    tick;
    checks++;
    if ({bus_req, mem_stall, mem_done} !== 3'b000) begin
      errors++; $display("FAIL flush_with_data got %b exp 000", {bus_req, mem_stall, mem_done});
    end
    // flush in ADDR: request stays up until accepted, then result discarded
    mem_req = 1; mem_addr = 32'h3010;
    tick;
    flush = 1; mem_req = 0;
    #1;
    checks++;
    if ({bus_req, mem_stall} !== 2'b11) begin
      errors++; $display("FAIL flush_addr got %b exp 11", {bus_req, mem_stall});
    end
    tick;
    flush = 0; bus_addr_ok = 1;
    #1;
    checks++;
    if ({bus_req, mem_stall} !== 2'b11) begin
      errors++; $display("FAIL flush_addr_hold got %b exp 11", {bus_req, mem_stall});
    end
    tick;
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3333_4444;
    #1;
    checks++;
    if ({bus_req, mem_stall, mem_done} !== 3'b000) begin
      errors++; $display("FAIL flush_addr_data got %b exp 000", {bus_req, mem_stall, mem_done});
    end
    tick;
    bus_data_ok = 0;
    #1;
    tick;
    checks++;
    if ({bus_req, mem_stall, mem_done} !== 3'b000) begin
      errors++; $display("FAIL flush_addr_end got %b exp 000", {bus_req, mem_stall, mem_done});
    end
  endtask

  task automatic test_reset_in_addr;
    mem_req = 1; mem_we = 1; mem_size = 2'd2; mem_wen = 4'hF; mem_addr = 32'h4000; mem_wdata = 32'h7777_8888;
    tick;
    checks++;
    if (bus_req !== 1'b1) begin errors++; $display("FAIL rst_addr_pre got %b exp 1", bus_req); end
    reset = 1; mem_req = 0;
    tick;
    reset = 0;
    #1;
    checks++;
    if ({bus_req, mem_stall, mem_done, mem_rdata, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !== '0) begin
      errors++;
      $display("FAIL rst_addr got req=%b stall=%b done=%b rdata=%h wr=%b wstrb=%b addr=%h exp all zero",
               bus_req, mem_stall, mem_done, mem_rdata, bus_wr, bus_wstrb, bus_addr);
    end
    run_txn(0, 2'd2, 4'b1111, 32'h4004, 32'h0, 32'h5555_AAAA, 1, 1, 0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 25; i++) begin
      logic [1:0]  sz = 2'($urandom_range(0, 2));
      logic [31:0] a = $urandom;
      logic [31:0] v = $urandom;
      logic [3:0]  wen;
      logic [31:0] wd;
      a = sz == 2'd2 ? {a[31:2], 2'b00} : sz == 2'd1 ? {a[31:1], 1'b0} : a;
      wen = sz == 2'd2 ? 4'b1111 : sz == 2'd1 ? 4'(3 << a[1:0]) : 4'(1 << a[1:0]);
      wd = sz == 2'd2 ? v : sz == 2'd1 ? {2{v[15:0]}} : {4{v[7:0]}};
      run_txn(1'($urandom), sz, wen, a, wd, $urandom, $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store_slow();
    test_hold();
    test_flush();
    test_reset_in_addr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
